// File: rtl/fifo_tx_pkg.sv
// ---------------------------------------------------------------------------
// fifo_tx_pkg
// Shared definitions for the FIFO-to-UART transmit scheduler:
//   - DEFAULT_DATA_WIDTH : default byte width for the FIFO and UART side
//   - ST_*_ENC           : state encodings for the scheduler FSM
//   - state_t            : FSM state enum built from those encodings
//   - gapLoadValue / gapCounterWidth : helpers for sizing the gap timer
// Optional feature macro: FIFO_TX_GAP_EN adds the GAP state.
// ---------------------------------------------------------------------------
package fifo_tx_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
   localparam logic [2:0] ST_POP_ENC       = 3'd1;
   localparam logic [2:0] ST_LATCH_ENC     = 3'd2;
   localparam logic [2:0] ST_START_ENC     = 3'd3;
   localparam logic [2:0] ST_WAIT_DONE_ENC = 3'd4;
   localparam logic [2:0] ST_GAP_ENC       = 3'd5;

`ifdef FIFO_TX_GAP_EN
   typedef enum logic [2:0] {
      ST_IDLE      = ST_IDLE_ENC,
      ST_POP       = ST_POP_ENC,
      ST_LATCH     = ST_LATCH_ENC,
      ST_START     = ST_START_ENC,
      ST_WAIT_DONE = ST_WAIT_DONE_ENC,
      ST_GAP       = ST_GAP_ENC
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE      = ST_IDLE_ENC,
      ST_POP       = ST_POP_ENC,
      ST_LATCH     = ST_LATCH_ENC,
      ST_START     = ST_START_ENC,
      ST_WAIT_DONE = ST_WAIT_DONE_ENC
   } state_t;
`endif

   // The timer counts down to zero while in GAP, so loading N-1 gives N
   // cycles in GAP. A zero gap request still spends one cycle there.
   function automatic int gapLoadValue(input int gapCycles);
      return (gapCycles > 0) ? gapCycles - 1 : 0;
   endfunction

   // Smallest counter width (at least 1) that can hold the load value.
   function automatic int gapCounterWidth(input int gapCycles);
      int value;
      int width;
      value = gapLoadValue(gapCycles);
      width = 1;
      while ((value >> width) != 0) begin
         width = width + 1;
      end
      return width;
   endfunction

endpackage

// File: rtl/fifo_tx_gap_timer.sv
// ---------------------------------------------------------------------------
// fifo_tx_gap_timer
// Loadable down-counter with a zero flag, used to time the idle gap between
// transmitted bytes. Only instantiated when FIFO_TX_GAP_EN is defined.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset, clears the count
//   load_i       load loadValue_i into the counter (has priority over dec_i)
//   dec_i        decrement by one, saturating at zero
//   loadValue_i  value to load
//   zero_o       high while the count is zero
// ---------------------------------------------------------------------------
module fifo_tx_gap_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             dec_i,
   input  logic [WIDTH-1:0] loadValue_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q;

   // Load wins over decrement; decrement stops at zero so a late dec_i
   // can never wrap the counter back up.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= loadValue_i;
      end else if (dec_i && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/fifo_tx_scheduler.sv
// ---------------------------------------------------------------------------
// fifo_tx_scheduler
// Pops bytes from a FIFO one at a time and hands each to a UART transmitter,
// counting completed bytes. Optional macro FIFO_TX_GAP_EN inserts GAP_CYCLES
// idle cycles after every completed byte.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset, aborts any transfer
//   enable      permits new FIFO pops when high
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  single-cycle FIFO pop strobe
//   tx_ready    UART transmitter idle
//   tx_done     single-cycle UART byte-complete tick
//   tx_start    single-cycle UART load strobe
//   tx_data     byte presented to the UART, held between latches
//   byte_count  completed byte count, wraps silently
//   busy        high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module fifo_tx_scheduler
   import fifo_tx_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int GAP_CYCLES  = 16,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   fifo_empty,
   input  logic [DATA_WIDTH-1:0]  fifo_dout,
   output logic                   fifo_rd_en,
   input  logic                   tx_ready,
   input  logic                   tx_done,
   output logic                   tx_start,
   output logic [DATA_WIDTH-1:0]  tx_data,
   output logic [COUNT_WIDTH-1:0] byte_count,
   output logic                   busy
);

   state_t                 state_q, state_d;
   logic                   rdEn_q, rdEn_d;
   logic                   txStart_q, txStart_d;
   logic [DATA_WIDTH-1:0]  txData_q, txData_d;
   logic [COUNT_WIDTH-1:0] byteCount_q, byteCount_d;

`ifdef FIFO_TX_GAP_EN
   localparam int GAP_W = gapCounterWidth(GAP_CYCLES);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(gapLoadValue(GAP_CYCLES));

   logic gapLoad;
   logic gapDec;
   logic gapZero;

   fifo_tx_gap_timer #(
      .WIDTH(GAP_W)
   ) uGapTimer (
      .clk         (clk),
      .reset       (reset),
      .load_i      (gapLoad),
      .dec_i       (gapDec),
      .loadValue_i (GAP_LOAD),
      .zero_o      (gapZero)
   );
`endif

   // Next-state and next-output logic. Strobe outputs are computed one cycle
   // ahead so that they come straight out of flops in the state they belong
   // to. tx_start is armed on the way out of LATCH from the current tx_ready
   // so it can fire in the first START cycle; if the UART is busy, START
   // keeps polling tx_ready and fires one cycle after it rises.
   always_comb begin
      state_d     = state_q;
      rdEn_d      = 1'b0;
      txStart_d   = 1'b0;
      txData_d    = txData_q;
      byteCount_d = byteCount_q;
`ifdef FIFO_TX_GAP_EN
      gapLoad     = 1'b0;
      gapDec      = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (enable && !fifo_empty) begin
               state_d = ST_POP;
               rdEn_d  = 1'b1;
            end
         end
         ST_POP: begin
            state_d = ST_LATCH;
         end
         ST_LATCH: begin
            txData_d  = fifo_dout;
            txStart_d = tx_ready;
            state_d   = ST_START;
         end
         ST_START: begin
            if (txStart_q) begin
               state_d = ST_WAIT_DONE;
            end else begin
               txStart_d = tx_ready;
            end
         end
         ST_WAIT_DONE: begin
            // enable is deliberately not looked at here: a byte in flight
            // always completes and is always counted.
            if (tx_done) begin
               byteCount_d = byteCount_q + 1'b1;
`ifdef FIFO_TX_GAP_EN
               gapLoad     = 1'b1;
               state_d     = ST_GAP;
`else
               state_d     = ST_IDLE;
`endif
            end
         end
`ifdef FIFO_TX_GAP_EN
         ST_GAP: begin
            gapDec = 1'b1;
            if (gapZero) begin
               state_d = ST_IDLE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Reset clears everything, including a half-finished transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rdEn_q      <= 1'b0;
         txStart_q   <= 1'b0;
         txData_q    <= '0;
         byteCount_q <= '0;
      end else begin
         state_q     <= state_d;
         rdEn_q      <= rdEn_d;
         txStart_q   <= txStart_d;
         txData_q    <= txData_d;
         byteCount_q <= byteCount_d;
      end
   end

   assign fifo_rd_en = rdEn_q;
   assign tx_start   = txStart_q;
   assign tx_data    = txData_q;
   assign byte_count = byteCount_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fifo_tx_scheduler
// Directed bench for fifo_tx_scheduler with a small FIFO model and a
// scoreboard of expected bytes. Works with or without FIFO_TX_GAP_EN.
// ---------------------------------------------------------------------------
module tb_fifo_tx_scheduler;

   localparam int DW  = 8;
   localparam int GAP = 4;
   localparam int CW  = 4;

`ifdef FIFO_TX_GAP_EN
   localparam bit GAP_ON = 1'b1;
`else
   localparam bit GAP_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          fifo_empty;
   logic [DW-1:0] fifo_dout;
   logic          fifo_rd_en;
   logic          tx_ready;
   logic          tx_done;
   logic          tx_start;
   logic [DW-1:0] tx_data;
   logic [CW-1:0] byte_count;
   logic          busy;

   int compared   = 0;
   int mismatched = 0;
   int expCount   = 0;

   logic [DW-1:0] fifoQ[$];
   logic [DW-1:0] expQ[$];
   logic [DW-1:0] monExp;
   logic          popPending;

   fifo_tx_scheduler #(
      .DATA_WIDTH  (DW),
      .GAP_CYCLES  (GAP),
      .COUNT_WIDTH (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .tx_ready   (tx_ready),
      .tx_done    (tx_done),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .byte_count (byte_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // One comparison: counts it, and reports it when it does not match.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared = compared + 1;
      if (actual !== expected) begin
         mismatched = mismatched + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Advance one clock. The FIFO model pops on the edge that ends a cycle
   // with fifo_rd_en high, so new data appears just after that edge.
   task automatic tick();
      @(negedge clk);
      popPending = fifo_rd_en;
      @(posedge clk);
      #1;
      if (popPending && (fifoQ.size() > 0)) begin
         fifo_dout = fifoQ.pop_front();
      end
      fifo_empty = (fifoQ.size() == 0);
   endtask

   // Queue a byte in the FIFO model and expect it on the UART side.
   task automatic applyStimulus(input logic [DW-1:0] b);
      fifoQ.push_back(b);
      expQ.push_back(b);
      fifo_empty = 1'b0;
   endtask

   task automatic pulseDone();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   task automatic waitStart(input int bound);
      int n;
      n = 0;
      while (!tx_start && (n < bound)) begin
         tick();
         n = n + 1;
      end
      if (!tx_start) begin
         compared   = compared + 1;
         mismatched = mismatched + 1;
         $display("[TB] FAIL startTimeout: no tx_start within %0d cycles", bound);
      end
   endtask

   task automatic completeByte();
      waitStart(60);
      tick();
      tick();
      pulseDone();
   endtask

   task automatic bumpCount();
      expCount = (expCount + 1) % (1 << CW);
   endtask

   // Scoreboard monitor: every tx_start must carry the next expected byte.
   always @(negedge clk) begin
      if (tx_start) begin
         if (expQ.size() == 0) begin
            compared   = compared + 1;
            mismatched = mismatched + 1;
            $display("[TB] FAIL unexpectedStart: tx_start with data 0x%0h, expected none", tx_data);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("txDataOrder", 32'(tx_data), 32'(monExp));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int starts;
      int pops;
      int k;

      reset      = 1'b1;
      enable     = 1'b0;
      tx_ready   = 1'b1;
      tx_done    = 1'b0;
      fifo_empty = 1'b1;
      fifo_dout  = '0;
      popPending = 1'b0;

      // Reset values
      tick();
      tick();
      checkOutput("rstRdEn",    32'(fifo_rd_en), 32'd0);
      checkOutput("rstTxStart", 32'(tx_start),   32'd0);
      checkOutput("rstTxData",  32'(tx_data),    32'd0);
      checkOutput("rstCount",   32'(byte_count), 32'd0);
      checkOutput("rstBusy",    32'(busy),       32'd0);
      reset = 1'b0;
      tick();

      // Single byte latency: pop at N+1, start with data at N+3
      enable = 1'b1;
      applyStimulus(8'h41);
      tick();
      checkOutput("popAtN1",  32'(fifo_rd_en), 32'd1);
      checkOutput("busyAtN1", 32'(busy),       32'd1);
      tick();
      checkOutput("singlePop", 32'(fifo_rd_en), 32'd0);
      tick();
      checkOutput("startAtN3",  32'(tx_start), 32'd1);
      checkOutput("dataAtN3",   32'(tx_data),  32'h41);
      tick();
      tick();
      pulseDone();
      bumpCount();
      checkOutput("countAfter41", 32'(byte_count), 32'(expCount));

      // UART not ready: START must hold without strobing or popping again
      tx_ready = 1'b0;
      applyStimulus(8'h5A);
      applyStimulus(8'h6B);
      tick();
      tick();
      tick();
      checkOutput("startHeldLow", 32'(tx_start), 32'd0);
      starts = 0;
      pops   = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         starts = starts + int'(tx_start);
         pops   = pops + int'(fifo_rd_en);
      end
      checkOutput("noStartNotReady", 32'(starts), 32'd0);
      checkOutput("noPopNotReady",   32'(pops),   32'd0);
      checkOutput("busyNotReady",    32'(busy),   32'd1);
      tx_ready = 1'b1;
      starts = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         starts = starts + int'(tx_start);
      end
      checkOutput("oneStartOnReady", 32'(starts), 32'd1);
      pulseDone();
      bumpCount();
      checkOutput("countAfter5A", 32'(byte_count), 32'(expCount));
      completeByte();
      bumpCount();
      checkOutput("countAfter6B", 32'(byte_count), 32'(expCount));

      // Stray tx_done outside WAIT_DONE must not count
      for (int i = 0; i < 10; i++) tick();
      pulseDone();
      checkOutput("strayDoneCount", 32'(byte_count), 32'(expCount));
      checkOutput("strayDoneBusy",  32'(busy),       32'd0);

      // Three bytes back to back; spacing from tx_done to next pop
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      applyStimulus(8'h03);
      for (int b = 0; b < 3; b++) begin
         completeByte();
         bumpCount();
         checkOutput("countBurst",  32'(byte_count), 32'(expCount));
         checkOutput("busyAfterDone", 32'(busy), 32'(GAP_ON));
         if (b < 2) begin
            k = 0;
            while (!fifo_rd_en && (k < 40)) begin
               tick();
               k = k + 1;
            end
            checkOutput("doneToPopCycles", 32'(k), GAP_ON ? 32'(GAP + 1) : 32'd1);
         end
      end

      // enable drops together with tx_done: byte counts, no further pops
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      waitStart(60);
      tick();
      enable  = 1'b0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      bumpCount();
      checkOutput("countEnableDrop", 32'(byte_count), 32'(expCount));
      pops = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         pops = pops + int'(fifo_rd_en);
      end
      checkOutput("noPopDisabled",  32'(pops), 32'd0);
      checkOutput("idleDisabled",   32'(busy), 32'd0);
      enable = 1'b1;
      completeByte();
      bumpCount();
      checkOutput("countResume22", 32'(byte_count), 32'(expCount));
      completeByte();
      bumpCount();
      checkOutput("countResume33", 32'(byte_count), 32'(expCount));

      // Run the 4-bit counter through its wrap to zero
      for (int i = 0; i < 7; i++) begin
         applyStimulus(8'hA0 + 8'(i));
         completeByte();
         bumpCount();
         checkOutput("countToWrap", 32'(byte_count), 32'(expCount));
      end
      checkOutput("countWrapped", 32'(byte_count), 32'd0);

      // Reset in WAIT_DONE aborts the transfer
      applyStimulus(8'h77);
      waitStart(60);
      tick();
      reset = 1'b1;
      tick();
      checkOutput("abortRdEn",    32'(fifo_rd_en), 32'd0);
      checkOutput("abortTxStart", 32'(tx_start),   32'd0);
      checkOutput("abortTxData",  32'(tx_data),    32'd0);
      checkOutput("abortCount",   32'(byte_count), 32'd0);
      checkOutput("abortBusy",    32'(busy),       32'd0);
      reset    = 1'b0;
      expCount = 0;
      tick();

      // Normal operation after the abort
      applyStimulus(8'h99);
      completeByte();
      bumpCount();
      checkOutput("countAfterAbort", 32'(byte_count), 32'(expCount));

      for (int i = 0; i < 3; i++) tick();
      checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
